// File: rtl/gate_checker_if.sv
// Stimulus/response bundle between gate_checker (slave) and the gate block side (master).
// GATE_CHECKER_FAIL_CAPTURE_EN adds the first-failure capture signals.
interface gate_checker_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic             a;
    logic             b;
    logic             f, y, x, z, w, c, g;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
    logic             fail_valid;
    logic [1:0]       fail_vec;
    logic [6:0]       fail_mask;

    modport slave (
        input  start, f, y, x, z, w, c, g,
        output a, b, busy, done, pass, err_count, fail_valid, fail_vec, fail_mask
    );
    modport master (
        output start, f, y, x, z, w, c, g,
        input  a, b, busy, done, pass, err_count, fail_valid, fail_vec, fail_mask
    );
`else
    modport slave (
        input  start, f, y, x, z, w, c, g,
        output a, b, busy, done, pass, err_count
    );
    modport master (
        output start, f, y, x, z, w, c, g,
        input  a, b, busy, done, pass, err_count
    );
`endif
endinterface

// File: rtl/gate_checker.sv
// Sweeps {a,b} through 00..11 PASSES times, checks the seven gate outputs after a settle delay.
// GATE_CHECKER_FAIL_CAPTURE_EN adds capture of the first mismatching vector and its mask.
module gate_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int PASSES        = 1,
    parameter int ERR_W         = 8
) (
    input logic           i_clk,
    input logic           i_rst,
    gate_checker_if.slave bus
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [1:0]       r_vec;
    logic [PW-1:0]    r_pidx;
    logic [SW-1:0]    r_settle;
    logic             r_a, r_b, r_done, r_pass;
    logic [ERR_W-1:0] r_err;
    logic [6:0]       w_mask;
    logic             w_last, w_settled;

    // Mismatch mask is computed against the registered stimulus actually on the pins
    assign w_mask[0] = bus.f ^ ~r_a;
    assign w_mask[1] = bus.y ^ (r_a & r_b);
    assign w_mask[2] = bus.x ^ (r_a | r_b);
    assign w_mask[3] = bus.z ^ ~(r_a & r_b);
    assign w_mask[4] = bus.w ^ (r_a ^ r_b);
    assign w_mask[5] = bus.c ^ ~(r_a | r_b);
    assign w_mask[6] = bus.g ^ ~(r_a ^ r_b);

    assign w_last    = (r_vec == 2'b11) && (r_pidx == PW'(PASSES - 1));
    assign w_settled = (r_settle == SW'(SETTLE_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next = S_DRIVE;
            S_DRIVE:  w_next = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
            S_SETTLE: if (w_settled) w_next = S_CHECK;
            S_CHECK:  w_next = w_last ? S_DONE : S_DRIVE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
    logic       r_fvalid;
    logic [1:0] r_fvec;
    logic [6:0] r_fmask;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fvalid <= 1'b0;
            r_fvec   <= 2'b00;
            r_fmask  <= 7'd0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_fvalid <= 1'b0;
            r_fvec   <= 2'b00;
            r_fmask  <= 7'd0;
        end else if (r_state == S_CHECK && (|w_mask) && !r_fvalid) begin
            r_fvalid <= 1'b1;
            r_fvec   <= {r_a, r_b};
            r_fmask  <= w_mask;
        end
    end

    assign bus.fail_valid = r_fvalid;
    assign bus.fail_vec   = r_fvec;
    assign bus.fail_mask  = r_fmask;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vec    <= 2'b00;
            r_pidx   <= '0;
            r_settle <= '0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_err  <= '0;
                        r_pass <= 1'b0;
                        r_vec  <= 2'b00;
                        r_pidx <= '0;
                    end
                end
                S_DRIVE: begin
                    r_a      <= r_vec[1];
                    r_b      <= r_vec[0];
                    r_settle <= '0;
                end
                S_SETTLE: r_settle <= r_settle + 1'b1;
                S_CHECK: begin
                    // One count per failing vector, saturating
                    if ((|w_mask) && (r_err != '1)) r_err <= r_err + 1'b1;
                    r_vec <= r_vec + 2'd1;
                    if (r_vec == 2'b11) r_pidx <= r_pidx + 1'b1;
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    r_pass <= (r_err == '0);
                end
                default: ;
            endcase
        end
    end

    assign bus.a         = r_a;
    assign bus.b         = r_b;
    assign bus.busy      = (r_state == S_DRIVE) || (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err;
endmodule

// File: tb/tb_gate_checker.sv
// Directed bench for gate_checker: three instances (defaults, PASSES=3/SETTLE=0, ERR_W=2)
// each driven by a gate model with selectable faults.
module tb_gate_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   mode0 = 0, mode1 = 0, mode2 = 0;
    logic saw_done;

    always #5 clk = ~clk;

    gate_checker_if #(.ERR_W(8)) if0 ();
    gate_checker_if #(.ERR_W(8)) if1 ();
    gate_checker_if #(.ERR_W(2)) if2 ();

    gate_checker #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(8)) dut0 (.i_clk(clk), .i_rst(rst), .bus(if0));
    gate_checker #(.SETTLE_CYCLES(0), .PASSES(3), .ERR_W(8)) dut1 (.i_clk(clk), .i_rst(rst), .bus(if1));
    gate_checker #(.SETTLE_CYCLES(2), .PASSES(1), .ERR_W(2)) dut2 (.i_clk(clk), .i_rst(rst), .bus(if2));

    // mode: 0 good, 1 xor stuck 0, 2 nand stuck 1, 3 all outputs inverted
    function automatic logic [6:0] gates(input logic a, input logic b, input int mode);
        logic [6:0] o;
        o = {~(a ^ b), ~(a | b), a ^ b, ~(a & b), a | b, a & b, ~a};
        case (mode)
            1: o[4] = 1'b0;
            2: o[3] = 1'b1;
            3: o = ~o;
            default: ;
        endcase
        return o;
    endfunction

    assign {if0.g, if0.c, if0.w, if0.z, if0.x, if0.y, if0.f} = gates(if0.a, if0.b, mode0);
    assign {if1.g, if1.c, if1.w, if1.z, if1.x, if1.y, if1.f} = gates(if1.a, if1.b, mode1);
    assign {if2.g, if2.c, if2.w, if2.z, if2.x, if2.y, if2.f} = gates(if2.a, if2.b, mode2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        if0.start = 1'b0;
        if1.start = 1'b0;
        if2.start = 1'b0;
        repeat (3) tick();
        chk("rst_a", 32'(if0.a), 0);
        chk("rst_b", 32'(if0.b), 0);
        chk("rst_busy", 32'(if0.busy), 0);
        chk("rst_done", 32'(if0.done), 0);
        chk("rst_pass", 32'(if0.pass), 0);
        chk("rst_err", 32'(if0.err_count), 0);
        chk("rst_busy1", 32'(if1.busy), 0);
        chk("rst_err2", 32'(if2.err_count), 0);
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
        chk("rst_fvalid", 32'(if0.fail_valid), 0);
`endif
        rst = 1'b0;
        tick();

        // good model, default timing
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        chk("t1_busy", 32'(if0.busy), 1);
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 1 || k == 5 || k == 9 || k == 13)
                chk("t1_ab", 32'({if0.a, if0.b}), 32'((k - 1) / 4));
            if (k == 16) chk("t1_done16", 32'(if0.done), 0);
            if (k == 17) begin
                chk("t1_done17", 32'(if0.done), 1);
                chk("t1_pass", 32'(if0.pass), 1);
                chk("t1_err", 32'(if0.err_count), 0);
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
                chk("t1_fvalid", 32'(if0.fail_valid), 0);
`endif
            end
            if (k == 18) begin
                chk("t1_done18", 32'(if0.done), 0);
                chk("t1_passhold", 32'(if0.pass), 1);
                chk("t1_busy18", 32'(if0.busy), 0);
            end
        end

        // xor stuck at 0: vectors 01 and 10 fail
        mode0 = 1;
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 7) chk("t2_err7", 32'(if0.err_count), 0);
            if (k == 8) chk("t2_err8", 32'(if0.err_count), 1);
            if (k == 17) begin
                chk("t2_done", 32'(if0.done), 1);
                chk("t2_err", 32'(if0.err_count), 2);
                chk("t2_pass", 32'(if0.pass), 0);
`ifdef GATE_CHECKER_FAIL_CAPTURE_EN
                chk("t2_fvalid", 32'(if0.fail_valid), 1);
                chk("t2_fvec", 32'(if0.fail_vec), 32'b01);
                chk("t2_fmask", 32'(if0.fail_mask), 32'b0010000);
`endif
            end
        end

        // PASSES=3, SETTLE=0, nand stuck at 1
        mode1 = 2;
        if1.start = 1'b1;
        tick();
        if1.start = 1'b0;
        for (int k = 1; k <= 25; k++) begin
            tick();
            if (k == 24) chk("t3_done24", 32'(if1.done), 0);
            if (k == 25) begin
                chk("t3_done25", 32'(if1.done), 1);
                chk("t3_err", 32'(if1.err_count), 3);
                chk("t3_pass", 32'(if1.pass), 0);
            end
        end

        // ERR_W=2, all outputs inverted: saturates at 3
        mode2 = 3;
        if2.start = 1'b1;
        tick();
        if2.start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick();
            if (k == 17) begin
                chk("t4_done", 32'(if2.done), 1);
                chk("t4_err", 32'(if2.err_count), 3);
                chk("t4_pass", 32'(if2.pass), 0);
            end
        end

        // start pulsed mid-run is ignored
        mode0 = 0;
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            if (k == 5) if0.start = 1'b1;
            if (k == 6) if0.start = 1'b0;
            tick();
            if (k == 16) chk("t5_done16", 32'(if0.done), 0);
            if (k == 17) begin
                chk("t5_done17", 32'(if0.done), 1);
                chk("t5_pass", 32'(if0.pass), 1);
            end
        end
        tick();

        // reset at cycle 8 discards a partial count
        mode0 = 3;
        if0.start = 1'b1;
        tick();
        if0.start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 4) chk("t6_err4", 32'(if0.err_count), 1);
            if (k == 7) chk("t6_ab7", 32'({if0.a, if0.b}), 32'b01);
        end
        rst = 1'b1;
        tick();
        chk("t6_busy", 32'(if0.busy), 0);
        chk("t6_ab", 32'({if0.a, if0.b}), 0);
        chk("t6_err", 32'(if0.err_count), 0);
        chk("t6_done", 32'(if0.done), 0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            saw_done = saw_done | if0.done;
        end
        chk("t6_nodone", 32'(saw_done), 0);

        // reset beats start
        rst = 1'b1;
        if0.start = 1'b1;
        tick();
        rst = 1'b0;
        if0.start = 1'b0;
        tick();
        chk("t7_busy", 32'(if0.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/gate_checker.md
# gate_checker

Synthesizable stimulus-and-response checker for the seven-output two-input gate block (not/and/or/nand/xor/nor/xnor). It drives `a`/`b` through all four input combinations and samples the gate outputs after a programmable settle delay. Each sample is compared against the expected truth table. The block reports a mismatch count and a pass/fail verdict, so the gate block can be checked in hardware without a simulation testbench.

## Interface
Parameters:
- `SETTLE_CYCLES`, 2: cycles between driving a vector and sampling outputs (0 allowed)
- `PASSES`, 1: number of full 4-vector sweeps per run (≥1)
- `ERR_W`, 8: width of error counter

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  run request; sampled only in IDLE
- `a`  out  1  stimulus to gate block (registered)
- `b`  out  1  stimulus to gate block (registered)
- `f` `y` `x` `z` `w` `c` `g`  in  1 each  gate outputs: not a, and, or, nand, xor, nor, xnor
- `busy`  out  1  high from DRIVE through CHECK of last vector
- `done`  out  1  one-cycle pulse at run completion
- `pass`  out  1  1 if run completed with zero mismatching vectors; held until next start
- `err_count`  out  ERR_W  mismatching vectors this run, saturating

## Operation
- Vector order: {a,b} = 00, 01, 10, 11; repeated `PASSES` times.
- Expected outputs: f=~a, y=a&b, x=a|b, z=~(a&b), w=a^b, c=~(a|b), g=~(a^b).
- Mismatch mask bit order: [0]f [1]y [2]x [3]z [4]w [5]c [6]g.
- FSM states and transitions:
  - IDLE: `start` → DRIVE, clearing `err_count`, `pass`, vector index, and pass index.
  - DRIVE: register current vector onto `a`/`b`. If `SETTLE_CYCLES`=0, go to CHECK; otherwise go to SETTLE.
  - SETTLE: hold for `SETTLE_CYCLES` cycles, then go to CHECK.
  - CHECK: compare inputs to expected values. Any nonzero mask increments `err_count` by 1 (per vector, not per bit), saturating at all-ones. If more vectors remain, go to DRIVE; otherwise go to DONE.
  - DONE: `done`=1 for one cycle; `pass`=(final `err_count`==0). Then return to IDLE.
- `start` outside IDLE is ignored. `start` held high re-arms immediately after DONE.
- `a`/`b` hold the last driven vector while in IDLE.

## Timing
- Reset values: `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, state=IDLE.
- Per vector: 2+`SETTLE_CYCLES` cycles (DRIVE, settle, CHECK).
- `done` is asserted 4·`PASSES`·(2+`SETTLE_CYCLES`)+1 cycles after the edge that samples `start`. With defaults this is 17 cycles.
- CHECK samples inputs on the same edge that leaves CHECK. The result is visible in `err_count` on the following cycle.
- `rst` asserted mid-run aborts on the next edge:
  - all outputs return to reset values;
  - no `done` pulse is issued;
  - a partial `err_count` is discarded.
- Simultaneous `rst` and `start`: `rst` wins.

## Configuration
- `GATE_CHECKER_FAIL_CAPTURE_EN` defined: adds three outputs.
  - `fail_valid` (1): set on the first mismatching CHECK of a run.
  - `fail_vec` (2): the {a,b} of that vector.
  - `fail_mask` (7): the mismatch mask of that vector.
  - All three freeze once set and clear on reset or on an accepted `start`.
  - Later mismatches only increment `err_count`.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

## Test plan
- Correct gate model, defaults: pulse `start` → `done` at cycle 17, `pass`=1, `err_count`=0, a/b sequence 00,01,10,11.
- xor output stuck at 0: vectors 01 and 10 mismatch → `err_count`=2, `pass`=0. With capture enabled: `fail_vec`=01, `fail_mask`=7'b0010000.
- `PASSES`=3, `SETTLE_CYCLES`=0, nand output stuck at 1: `err_count`=3 (vector 11 fails once per sweep); `done` at cycle 25.
- `ERR_W`=2, all outputs inverted: every vector fails → `err_count` saturates at 3, `pass`=0.
- `start` pulsed again during the run: the run is unaffected and `done` is still at cycle 17. Assert `rst` at cycle 8: next cycle `busy`=0, a/b=00, `err_count`=0, and no `done` pulse.
